// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the shared-ALU arbiter and
// the result consumer.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_op1;
  logic [NREQ-1:0][31:0] req_op2;
  logic [NREQ-1:0][3:0]  req_funct;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;

  modport master (
    output req_valid, req_op1, req_op2, req_funct, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_funct, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a single-entry tagged result buffer on a valid/ready response channel.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_SLL  = 4'd2;
  localparam logic [3:0] FN_SLT  = 4'd3;
  localparam logic [3:0] FN_SLTU = 4'd4;
  localparam logic [3:0] FN_XOR  = 4'd5;
  localparam logic [3:0] FN_SRL  = 4'd6;
  localparam logic [3:0] FN_SRA  = 4'd7;
  localparam logic [3:0] FN_OR   = 4'd8;
  localparam logic [3:0] FN_AND  = 4'd9;

  function automatic logic [31:0] alu_eval(input logic [3:0] funct,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0] shamt;
    shamt = b[4:0];
    case (funct)
      FN_ADD:  alu_eval = a + b;
      FN_SUB:  alu_eval = a - b;
      FN_SLL:  alu_eval = a << shamt;
      FN_SLT:  alu_eval = {31'd0, ($signed(a) < $signed(b))};
      FN_SLTU: alu_eval = {31'd0, (a < b)};
      FN_XOR:  alu_eval = a ^ b;
      FN_SRL:  alu_eval = a >> shamt;
      FN_SRA:  alu_eval = $unsigned($signed(a) >>> shamt);
      FN_OR:   alu_eval = a | b;
      FN_AND:  alu_eval = a & b;
      default: alu_eval = {32{1'bx}};
    endcase
  endfunction

  logic [ID_W-1:0] rr_ptr_r;
  logic            resp_valid_r;
  logic [ID_W-1:0] resp_id_r;
  logic [31:0]     resp_result_r;

  logic            grant_found_s;
  logic [ID_W-1:0] grant_id_s;
  logic [ID_W-1:0] next_ptr_s;
  logic            can_accept_s;
  logic            accept_s;
  logic [31:0]     alu_result_s;
  int              sum_s;
  logic [ID_W-1:0] idx_s;

  assign can_accept_s = !resp_valid_r || bus.resp_ready;
  assign accept_s     = grant_found_s && can_accept_s;
  assign next_ptr_s   = (grant_id_s == ID_W'(NREQ - 1)) ? '0 : grant_id_s + ID_W'(1);
  assign alu_result_s = alu_eval(bus.req_funct[grant_id_s],
                                 bus.req_op1[grant_id_s],
                                 bus.req_op2[grant_id_s]);

  // Round-robin scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    sum_s         = 0;
    idx_s         = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s         = int'(rr_ptr_r) + i;
      sum_s         = (sum_s >= NREQ) ? (sum_s - NREQ) : sum_s;
      idx_s         = ID_W'(sum_s);
      grant_id_s    = (!grant_found_s && bus.req_valid[idx_s]) ? idx_s : grant_id_s;
      grant_found_s = grant_found_s | bus.req_valid[idx_s];
    end
  end

  // Accept strobe goes only to the granted requester, gated by buffer space.
  always_comb begin
    bus.req_ready             = '0;
    bus.req_ready[grant_id_s] = accept_s;
  end

  // Result buffer and round-robin pointer; a drain with no new handshake empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_r  <= 1'b0;
      resp_id_r     <= '0;
      resp_result_r <= 32'd0;
      rr_ptr_r      <= '0;
    end else if (accept_s) begin
      resp_valid_r  <= 1'b1;
      resp_id_r     <= grant_id_s;
      resp_result_r <= alu_result_s;
      rr_ptr_r      <= next_ptr_s;
    end else if (bus.resp_ready) begin
      resp_valid_r  <= 1'b0;
    end else begin
      resp_valid_r  <= resp_valid_r;
    end
  end

  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_id     = resp_id_r;
  assign bus.resp_result = resp_result_r;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational ALU instance between NREQ independent requesters, such as an execute unit, an address generator and a debug port. Selects one pending request per cycle by round-robin and evaluates it on the ALU. Registers the result into a single-entry output buffer, tagged with the requester ID, and returns it over a valid/ready response channel. Sits between issue logic and the writeback/consumer side of the core.

Parameters:
NREQ, 4, number of requesters (1..16)
ID_W, $clog2(NREQ) (minimum 1), width of the requester ID tag

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_op1  in  NREQ x RV32Consts::IntReg  operand 1 per requester
req_op2  in  NREQ x RV32Consts::IntReg  operand 2 per requester
req_funct  in  NREQ x ALUFuncts::Type  ALU operation per requester
resp_valid  out  1  output buffer holds a result
resp_ready  in  1  consumer accepts the result this cycle
resp_id  out  ID_W  index of the requester that produced the result
resp_result  out  RV32Consts::IntReg  registered ALU result

Behaviour:
- Reset, asynchronous:
  - resp_valid=0, resp_id=0, resp_result=0, rr_ptr=0.
  - A result buffered at reset time is discarded, not replayed.
- can_accept = !resp_valid || resp_ready.
- Grant (combinational):
  - Scan req_valid starting at index rr_ptr, upward with wrap to 0; the first set bit g is granted.
  - No valid request means no grant.
- req_ready[g] = can_accept; every other req_ready bit is 0.
  - req_ready depends combinationally on req_valid and resp_ready.
  - A requester must not make req_valid depend on req_ready.
- ALU inputs are muxed from requester g. The ALU is combinational; funct semantics and op2[4:0] shift masking are unchanged.
- Request handshake completes when req_valid[g] && req_ready[g] at a rising edge. On that edge:
  - resp_valid<=1.
  - resp_id<=g.
  - resp_result<=ALU result.
  - rr_ptr<=(g+1) mod NREQ.
- Edge with resp_valid && resp_ready and no handshake: resp_valid<=0. resp_id and resp_result hold their values.
- Edge with resp_valid && !resp_ready:
  - All state holds, including rr_ptr.
  - req_ready is all zero.
- Simultaneous drain and accept, i.e. resp_ready=1 and a new handshake on the same edge: the buffer is overwritten with the new result. There is no bubble.
- Latency: 1 cycle. A result accepted on edge k is visible on resp_* after edge k. Throughput is 1 result per cycle.
- A requester holds req_op1, req_op2 and req_funct stable while req_valid=1 and it is not yet accepted. Dropping req_valid before acceptance is legal; the request is simply not serviced.
- Fairness: with requesters continuously valid and no backpressure, each of them is serviced at least once every NREQ cycles.
- NREQ=1: the grant is always index 0 and resp_id is constantly 0.
- An undefined funct propagates the ALU's 'x result into resp_result. This is not checked.

Test Plan:
1. Reset: assert reset mid-cycle with a result buffered and resp_ready=0 -> resp_valid=0 and resp_result=0 immediately, asynchronously. After deassert, the first grant goes to req 0.
2. Single request: req1 ADD op1=5, op2=7, resp_ready=1 -> req_ready=4'b0010 that cycle. Next cycle resp_valid=1, resp_id=1, resp_result=12.
3. Round-robin: all 4 req_valid held high with resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 on consecutive cycles with no gaps. Drop req2 -> sequence skips 2.
4. Backpressure: buffer holds SUB 3-5=0xFFFFFFFE with resp_ready=0 for 3 cycles -> req_ready=0 and resp_* stable all 3 cycles. Raise resp_ready with req3 valid -> req3 accepted that same cycle, and resp_id=3 follows with no bubble.
5. Operation coverage through a shared port:
   - SRA 0x80000000 by op2=0x24 -> 0xF8000000 (shift amount masked to 4).
   - SLT op1=0xFFFFFFFF, op2=1 -> 1.
   - SLTU with the same operands -> 0.
6. Withdrawn request: req0 valid during backpressure, dropped before resp_ready rises -> req0 is never serviced, and rr_ptr does not advance because of it.
